alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

ID/EX issue stage that produces the `ALU_Cntrl`, `In1` and `In2` inputs consumed by the EX-stage ALU. It has three jobs:
- Decode `ALUOp`/funct fields into the 4-bit ALU control code.
- Register operands and control across the ID/EX boundary, with stall and flush.
- Optionally resolve RAW hazards by forwarding from EX/MEM and MEM/WB.

It sits between the register file/immediate generator and the ALU.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `REG_AW`, 5, register address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ID_Valid`  in  1  ID stage holds a real instruction.
- `Stall`  in  1  hold the ID/EX register.
- `Flush`  in  1  replace the ID/EX contents with a bubble.
- `ALUOp`  in  2  main-decoder class.
- `Funct3`  in  3  instruction bits [14:12].
- `Funct7b5`  in  1  instruction bit 30.
- `OpR`  in  1  instruction is R-type (enables SUB via `Funct7b5`).
- `ALUSrc`  in  1  1 selects `Imm` for `In2`.
- `Rs1`, `Rs2`, `Rd`  in  `REG_AW`  register addresses.
- `Rs1_Data`, `Rs2_Data`, `Imm`  in  `XLEN`  ID operands.
- `EXMEM_RegWrite`, `MEMWB_RegWrite`  in  1  the downstream stage writes its `Rd`.
- `EXMEM_Rd`, `MEMWB_Rd`  in  `REG_AW`  downstream destination registers.
- `EXMEM_Result`, `MEMWB_Result`  in  `XLEN`  downstream values.
- `EX_Valid`  out  1  registered valid.
- `ALU_Cntrl`  out  4  registered ALU code.
- `In1`, `In2`  out  `XLEN`  ALU operands.
- `Store_Data`  out  `XLEN`  forwarded rs2 value.
- `EX_Rd`  out  `REG_AW`  registered `Rd`.
- `Illegal`  out  1  registered decode-error flag.

## Operation
- Decode is combinational, in ID:
  - `ALUOp`=00 → ADD (0010).
  - `ALUOp`=01 → SUB (0110).
  - `ALUOp`=10, `Funct3`=000 → SUB if `OpR`&`Funct7b5`, else ADD.
  - `ALUOp`=10, `Funct3`=111 → AND (0000).
  - `ALUOp`=10, `Funct3`=110 → OR (0001).
  - Any other `Funct3`, or `ALUOp`=11 → ADD with `Illegal`=1.
- ID/EX register update priority is `rst` > `Flush` > `Stall` > load.
  - Load: capture the decoded code, `Illegal`, `ID_Valid`, `Rs1`, `Rs2`, `Rd`, data, `Imm`, `ALUSrc`.
  - Stall: all state holds.
  - Flush (also overrides a simultaneous Stall): bubble = `EX_Valid`=0, `ALU_Cntrl`=0010, `Illegal`=0, all data/addresses 0, `ALUSrc`=0.
- `Illegal` is qualified: it is registered as decode-error & `ID_Valid`.
- EX-side operand select is combinational from the registered state:
  - `fwd1` = forwarded rs1; `In1` = `fwd1`.
  - `fwd2` = forwarded rs2; `Store_Data` = `fwd2`.
  - `In2` = `ALUSrc` ? registered `Imm` : `fwd2`.
- Forwarding rule, per source `rsN`:
  - EX/MEM hit if `EXMEM_RegWrite` & `EXMEM_Rd`≠0 & `EXMEM_Rd`==`rsN` → use `EXMEM_Result`.
  - Else MEM/WB hit under the same conditions → use `MEMWB_Result`.
  - Else use the registered data.
  - EX/MEM always wins a double hit. Register x0 never forwards.
- Bubbles (`EX_Valid`=0) still drive outputs; downstream must ignore them.

## Timing
- Reset values, all asserted asynchronously: `EX_Valid`=0, `ALU_Cntrl`=0010, `Illegal`=0, `EX_Rd`=0, stored data 0. Consequently `In1`=`In2`=`Store_Data`=0, absent any forwarding hit.
- Latency: ID inputs at edge N appear on the registered outputs after edge N; the ALU consumes them in cycle N+1.
- Forward path is zero-latency: downstream results change `In1`/`In2` within the same cycle.
- Stall for k cycles: outputs frozen k cycles. Forwarding stays live, so values may update as producers retire.
- Reset release mid-stream: the first edge after deassert loads normally.

## Configuration
- `ALU_ISSUE_FORWARD_EN` defined: forwarding muxes as above.
- Macro undefined: `fwd1`/`fwd2` are the registered `Rs1_Data`/`Rs2_Data`. The `EXMEM_*`/`MEMWB_*` ports remain but are unused; hazard handling is the hazard unit's job (stalls).

## Structure
- Shared package `alu_pkg` holds:
  - ALU codes `ALU_AND`=0000, `ALU_OR`=0001, `ALU_ADD`=0010, `ALU_SUB`=0110.
  - `ALUOp` encodings `ALUOP_MEM`=00, `ALUOP_BR`=01, `ALUOP_FN`=10.
  - `Funct3` constants 000/110/111.
- Sub-module `alu_cntrl_decode`: combinational (`ALUOp`, `Funct3`, `Funct7b5`, `OpR`) → (`ALU_Cntrl`, error). It is reused by any future second issue slot.
- Remainder (register, forwarding) is inline.

## Test plan
- Reset asserted mid-cycle with `ID_Valid`=1 → outputs go immediately to `EX_Valid`=0, `ALU_Cntrl`=0010, `In1`=`In2`=0.
- `ALUOp`=10, `Funct3`=000, `OpR`=1, `Funct7b5`=1, `Rs1_Data`=7, `Rs2_Data`=3 → next cycle `ALU_Cntrl`=0110, `In1`=7, `In2`=3. Repeat with `OpR`=0 (addi, `ALUSrc`=1, `Imm`=5) → 0010, `In2`=5.
- `ALUOp`=10, `Funct3`=100, `ID_Valid`=1 → `Illegal`=1, `ALU_Cntrl`=0010. Same case with `ID_Valid`=0 → `Illegal`=0.
- `Stall`=1 for 3 cycles with changing ID inputs → outputs unchanged. `Stall`=1 with `Flush`=1 → bubble next cycle.
- With `ALU_ISSUE_FORWARD_EN` defined:
  - Registered `Rs1`=5; `EXMEM_Rd`=5/`EXMEM_Result`=0xAA; `MEMWB_Rd`=5/`MEMWB_Result`=0xBB, both writing → `In1`=0xAA.
  - Drop `EXMEM_RegWrite` → `In1`=0xBB.
  - `Rs1`=`EXMEM_Rd`=0 → `In1`=registered data.
- Forwarding with `ALUSrc`=1, `Rs2` hit → `In2`=`Imm`, `Store_Data`=forwarded value.
- Same forwarding stimulus built without the macro → `In1` = registered `Rs1_Data`.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU control codes, ALUOp classes and Funct3 constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // 4-bit control codes understood by the EX-stage ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_cntrl_decode.sv
// ============================================================================
// Module   : alu_cntrl_decode
// Brief    : Combinational ALUOp/funct decode to the 4-bit ALU control code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cntrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_r,
  output logic [3:0] alu_cntrl,
  output logic       decode_err
);

  always_comb begin
    alu_cntrl  = ALU_ADD;
    decode_err = 1'b0;
    case (alu_op)
      ALUOP_MEM: alu_cntrl = ALU_ADD;
      ALUOP_BR:  alu_cntrl = ALU_SUB;
      ALUOP_FN: begin
        case (funct3)
          // Only register-register ops may subtract; addi shares funct3 000
          F3_ADD_SUB: alu_cntrl = (op_r && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:     alu_cntrl = ALU_AND;
          F3_OR:      alu_cntrl = ALU_OR;
          default:    decode_err = 1'b1;
        endcase
      end
      default: decode_err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Brief    : ID/EX issue register with ALU decode and optional operand
//            forwarding (enabled by defining ALU_ISSUE_FORWARD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        Funct3,
  input  logic              Funct7b5,
  input  logic              OpR,
  input  logic              ALUSrc,
  input  logic [REG_AW-1:0] Rs1,
  input  logic [REG_AW-1:0] Rs2,
  input  logic [REG_AW-1:0] Rd,
  input  logic [XLEN-1:0]   Rs1_Data,
  input  logic [XLEN-1:0]   Rs2_Data,
  input  logic [XLEN-1:0]   Imm,
  input  logic              EXMEM_RegWrite,
  input  logic              MEMWB_RegWrite,
  input  logic [REG_AW-1:0] EXMEM_Rd,
  input  logic [REG_AW-1:0] MEMWB_Rd,
  input  logic [XLEN-1:0]   EXMEM_Result,
  input  logic [XLEN-1:0]   MEMWB_Result,
  output logic              EX_Valid,
  output logic [3:0]        ALU_Cntrl,
  output logic [XLEN-1:0]   In1,
  output logic [XLEN-1:0]   In2,
  output logic [XLEN-1:0]   Store_Data,
  output logic [REG_AW-1:0] EX_Rd,
  output logic              Illegal
);

  logic [3:0]        dec_cntrl;
  logic              dec_err;

  logic              ex_valid;
  logic [3:0]        ex_cntrl;
  logic              ex_illegal;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic              ex_alusrc;

  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;

  alu_cntrl_decode u_decode (
    .alu_op     (ALUOp),
    .funct3     (Funct3),
    .funct7b5   (Funct7b5),
    .op_r       (OpR),
    .alu_cntrl  (dec_cntrl),
    .decode_err (dec_err)
  );

  // Flush outranks Stall so a squashed instruction never lingers in EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst || Flush) begin
      ex_valid    <= 1'b0;
      ex_cntrl    <= ALU_ADD;
      ex_illegal  <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_alusrc   <= 1'b0;
    end else if (!Stall) begin
      ex_valid    <= ID_Valid;
      ex_cntrl    <= dec_cntrl;
      ex_illegal  <= dec_err & ID_Valid;
      ex_rs1      <= Rs1;
      ex_rs2      <= Rs2;
      ex_rd       <= Rd;
      ex_rs1_data <= Rs1_Data;
      ex_rs2_data <= Rs2_Data;
      ex_imm      <= Imm;
      ex_alusrc   <= ALUSrc;
    end
  end

`ifdef ALU_ISSUE_FORWARD_EN
  logic exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;

  // x0 is hard-wired zero, so a write to it must never be forwarded
  assign exmem_hit1 = EXMEM_RegWrite && (EXMEM_Rd != '0) && (EXMEM_Rd == ex_rs1);
  assign exmem_hit2 = EXMEM_RegWrite && (EXMEM_Rd != '0) && (EXMEM_Rd == ex_rs2);
  assign memwb_hit1 = MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == ex_rs1);
  assign memwb_hit2 = MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == ex_rs2);

  always_comb begin
    fwd1 = ex_rs1_data;
    if (exmem_hit1)      fwd1 = EXMEM_Result;
    else if (memwb_hit1) fwd1 = MEMWB_Result;

    fwd2 = ex_rs2_data;
    if (exmem_hit2)      fwd2 = EXMEM_Result;
    else if (memwb_hit2) fwd2 = MEMWB_Result;
  end
`else
  logic unused_fwd;

  // Hazards are resolved by stalling upstream; downstream ports are ignored
  assign fwd1       = ex_rs1_data;
  assign fwd2       = ex_rs2_data;
  assign unused_fwd = ^{EXMEM_RegWrite, EXMEM_Rd, EXMEM_Result,
                        MEMWB_RegWrite, MEMWB_Rd, MEMWB_Result,
                        ex_rs1, ex_rs2};
`endif

  assign In1        = fwd1;
  assign In2        = ex_alusrc ? ex_imm : fwd2;
  assign Store_Data = fwd2;
  assign EX_Valid   = ex_valid;
  assign ALU_Cntrl  = ex_cntrl;
  assign EX_Rd      = ex_rd;
  assign Illegal    = ex_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Self-checking bench for alu_issue_stage against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ID_Valid, Stall, Flush;
  logic [1:0]        ALUOp;
  logic [2:0]        Funct3;
  logic              Funct7b5, OpR, ALUSrc;
  logic [REG_AW-1:0] Rs1, Rs2, Rd;
  logic [XLEN-1:0]   Rs1_Data, Rs2_Data, Imm;
  logic              EXMEM_RegWrite, MEMWB_RegWrite;
  logic [REG_AW-1:0] EXMEM_Rd, MEMWB_Rd;
  logic [XLEN-1:0]   EXMEM_Result, MEMWB_Result;
  logic              EX_Valid;
  logic [3:0]        ALU_Cntrl;
  logic [XLEN-1:0]   In1, In2, Store_Data;
  logic [REG_AW-1:0] EX_Rd;
  logic              Illegal;

  alu_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .Stall(Stall), .Flush(Flush),
    .ALUOp(ALUOp), .Funct3(Funct3), .Funct7b5(Funct7b5), .OpR(OpR), .ALUSrc(ALUSrc),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data), .Imm(Imm),
    .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
    .EXMEM_Rd(EXMEM_Rd), .MEMWB_Rd(MEMWB_Rd),
    .EXMEM_Result(EXMEM_Result), .MEMWB_Result(MEMWB_Result),
    .EX_Valid(EX_Valid), .ALU_Cntrl(ALU_Cntrl), .In1(In1), .In2(In2),
    .Store_Data(Store_Data), .EX_Rd(EX_Rd), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the instruction currently held in EX
  logic              m_valid, m_ill, m_src;
  logic [3:0]        m_code;
  logic [REG_AW-1:0] m_rs1, m_rs2, m_rd;
  logic [XLEN-1:0]   m_d1, m_d2, m_imm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7, input logic opr);
    // returns {error, code}
    if (op == 2'd0) return {1'b0, 4'd2};
    if (op == 2'd1) return {1'b0, 4'd6};
    if (op == 2'd3) return {1'b1, 4'd2};
    if (f3 == 3'd0) return {1'b0, (opr && f7) ? 4'd6 : 4'd2};
    if (f3 == 3'd7) return {1'b0, 4'd0};
    if (f3 == 3'd6) return {1'b0, 4'd1};
    return {1'b1, 4'd2};
  endfunction

  function automatic logic [XLEN-1:0] ref_fwd(input logic [REG_AW-1:0] rs,
                                              input logic [XLEN-1:0] data);
`ifdef ALU_ISSUE_FORWARD_EN
    if (EXMEM_RegWrite && EXMEM_Rd == rs && rs != 0) return EXMEM_Result;
    if (MEMWB_RegWrite && MEMWB_Rd == rs && rs != 0) return MEMWB_Result;
`endif
    return data;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_ill = 0; m_src = 0; m_code = 4'd2;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
  endtask

  task automatic model_edge();
    logic [4:0] d;
    d = ref_decode(ALUOp, Funct3, Funct7b5, OpR);
    if (rst || Flush) model_clear();
    else if (!Stall) begin
      m_valid = ID_Valid; m_code = d[3:0]; m_ill = d[4] && ID_Valid;
      m_rs1 = Rs1; m_rs2 = Rs2; m_rd = Rd;
      m_d1 = Rs1_Data; m_d2 = Rs2_Data; m_imm = Imm; m_src = ALUSrc;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [XLEN-1:0] f1, f2;
    f1 = ref_fwd(m_rs1, m_d1);
    f2 = ref_fwd(m_rs2, m_d2);
    check({tag, ".valid"}, 64'(EX_Valid),   64'(m_valid));
    check({tag, ".cntrl"}, 64'(ALU_Cntrl),  64'(m_code));
    check({tag, ".ill"},   64'(Illegal),    64'(m_ill));
    check({tag, ".rd"},    64'(EX_Rd),      64'(m_rd));
    check({tag, ".in1"},   64'(In1),        64'(f1));
    check({tag, ".in2"},   64'(In2),        64'(m_src ? m_imm : f2));
    check({tag, ".st"},    64'(Store_Data), 64'(f2));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic set_id(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic opr, input logic src,
                        input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2,
                        input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d1,
                        input logic [XLEN-1:0] d2, input logic [XLEN-1:0] im);
    ID_Valid = v; ALUOp = op; Funct3 = f3; Funct7b5 = f7; OpR = opr; ALUSrc = src;
    Rs1 = r1; Rs2 = r2; Rd = rd; Rs1_Data = d1; Rs2_Data = d2; Imm = im;
  endtask

  task automatic rand_id();
    logic [2:0] f3s [4];
    f3s = '{3'd0, 3'd6, 3'd7, 3'($urandom)};
    set_id(1'($urandom), 2'($urandom), f3s[$urandom_range(0, 3)], 1'($urandom),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic rand_down();
    EXMEM_RegWrite = 1'($urandom); MEMWB_RegWrite = 1'($urandom);
    EXMEM_Rd = 5'($urandom_range(0, 3)); MEMWB_Rd = 5'($urandom_range(0, 3));
    EXMEM_Result = $urandom; MEMWB_Result = $urandom;
  endtask

  initial begin
    rst = 1'b1; Stall = 0; Flush = 0;
    set_id(0, 2'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EXMEM_RegWrite = 0; MEMWB_RegWrite = 0; EXMEM_Rd = 0; MEMWB_Rd = 0;
    EXMEM_Result = 0; MEMWB_Result = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // R-type SUB, then addi
    set_id(1, 2'd2, 3'd0, 1, 1, 0, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'd0);
    cycle("sub");
    check("sub.code", 64'(ALU_Cntrl), 64'h6);
    check("sub.in1", 64'(In1), 64'd7);
    check("sub.in2", 64'(In2), 64'd3);
    set_id(1, 2'd2, 3'd0, 1, 0, 1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'd5);
    cycle("addi");
    check("addi.code", 64'(ALU_Cntrl), 64'h2);
    check("addi.in2", 64'(In2), 64'd5);

    // Illegal funct3, qualified by ID_Valid
    set_id(1, 2'd2, 3'd4, 0, 1, 0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0);
    cycle("ill");
    check("ill.flag", 64'(Illegal), 64'd1);
    ID_Valid = 0;
    cycle("ill_nv");
    check("ill_nv.flag", 64'(Illegal), 64'd0);

    // Stall holds for three cycles, then stall+flush bubbles
    set_id(1, 2'd2, 3'd7, 0, 1, 0, 5'd1, 5'd2, 5'd9, 32'h1234, 32'h5678, 32'd0);
    cycle("preload");
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle("stall");
      check("stall.rd", 64'(EX_Rd), 64'd9);
    end
    Flush = 1;
    cycle("flush");
    check("flush.valid", 64'(EX_Valid), 64'd0);
    Flush = 0; Stall = 0;

    // Directed forwarding scenario, held by stall while downstream changes
    set_id(1, 2'd0, 3'd0, 0, 0, 1, 5'd5, 5'd6, 5'd1, 32'h11, 32'h22, 32'h33);
    cycle("fwd_load");
    Stall = 1;
    EXMEM_RegWrite = 1; EXMEM_Rd = 5'd5; EXMEM_Result = 32'hAA;
    MEMWB_RegWrite = 1; MEMWB_Rd = 5'd5; MEMWB_Result = 32'hBB;
    #1 check_outputs("fwd_both");
`ifdef ALU_ISSUE_FORWARD_EN
    check("fwd_both.in1", 64'(In1), 64'hAA);
`else
    check("fwd_both.in1", 64'(In1), 64'h11);
`endif
    EXMEM_RegWrite = 0;
    #1 check_outputs("fwd_memwb");
    MEMWB_Rd = 5'd6;
    #1 check_outputs("fwd_rs2");
    check("fwd_rs2.in2", 64'(In2), 64'h33);
    Stall = 0;
    set_id(1, 2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd1, 32'h44, 32'h55, 32'h0);
    EXMEM_RegWrite = 1; EXMEM_Rd = 5'd0; MEMWB_Rd = 5'd0;
    cycle("fwd_x0");
    check("fwd_x0.in1", 64'(In1), 64'h44);

    // Randomized traffic with mid-cycle downstream changes
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rand_down();
      Stall = ($urandom_range(0, 9) < 2);
      Flush = ($urandom_range(0, 9) < 1);
      cycle("rnd");
      rand_down();
      #1 check_outputs("rnd_live");
    end

    // Asynchronous reset mid-cycle, then release and load normally
    Stall = 0; Flush = 0;
    set_id(1, 2'd2, 3'd6, 0, 1, 0, 5'd2, 5'd3, 5'd4, 32'h99, 32'h77, 32'h0);
    cycle("pre_rst");
    #2 rst = 1'b1;
    model_clear();
    #1 check_outputs("async_rst");
    check("async_rst.in1", 64'(In1), 64'd0);
    cycle("rst_hold");
    rst = 1'b0;
    cycle("post_rst");
    check("post_rst.code", 64'(ALU_Cntrl), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
